// File: rtl/mc_control_unit_if.sv
// Control bundle between the multicycle MIPS main control FSM and its datapath.
// master = control unit (drives selects/strobes), slave = datapath side.
interface mc_control_unit_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       ab_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       epc_write;
    logic [4:0] state_dbg;

    modport master (
        input  opcode, funct, zero,
        output pc_write, pc_write_cond, i_or_d, mem_write, ir_write, ab_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, epc_write, state_dbg
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_write, pc_write_cond, i_or_d, mem_write, ir_write, ab_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, epc_write, state_dbg
    );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle MIPS main control FSM (Moore, except branch pc_write_cond).
// Optional exception state enabled by defining MC_CTRL_EXCEPTION_EN.
module mc_control_unit #(
    parameter int MEM_WAIT       = 2,
    parameter int EXC_VECTOR_SEL = 3
) (
    input  logic               clk,
    input  logic               reset,
    mc_control_unit_if.master  bus
);

    typedef enum logic [4:0] {
        S_RESET     = 5'd0,
        S_FETCH     = 5'd1,
        S_FWAIT     = 5'd2,
        S_DECODE    = 5'd3,
        S_R_EXEC    = 5'd4,
        S_R_WB      = 5'd5,
        S_ADDI_EXEC = 5'd6,
        S_ADDI_WB   = 5'd7,
        S_MEM_ADDR  = 5'd8,
        S_LW_READ   = 5'd9,
        S_LW_WB     = 5'd10,
        S_SW_WRITE  = 5'd11,
        S_BEQ       = 5'd12,
        S_BNE       = 5'd13,
        S_JUMP      = 5'd14
`ifdef MC_CTRL_EXCEPTION_EN
        , S_EXC     = 5'd15
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;

    localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT - 1);

`ifdef MC_CTRL_EXCEPTION_EN
    localparam state_t ILLEGAL_NEXT = S_EXC;
`else
    localparam state_t ILLEGAL_NEXT = S_FETCH;
`endif

    // Out-of-range configuration is rejected at elaboration.
    if (MEM_WAIT < 1 || MEM_WAIT > 7 || EXC_VECTOR_SEL < 0 || EXC_VECTOR_SEL > 3) begin : g_param_check
        $error("mc_control_unit: MEM_WAIT must be 1..7 and EXC_VECTOR_SEL 0..3");
    end

    state_t     state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic [2:0] r_op;
    logic       r_legal;

    // R-type function decode; IR is stable from DECODE to the end of the instruction.
    always_comb begin
        r_op    = 3'b000;
        r_legal = 1'b1;
        case (bus.funct)
            6'h20:   r_op = ALU_ADD;
            6'h22:   r_op = ALU_SUB;
            6'h24:   r_op = ALU_AND;
            default: r_legal = 1'b0;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RESET;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx          = state;
        cnt_nx            = cnt;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.ab_write      = 1'b0;
        bus.reg_dst       = 2'd0;
        bus.mem_to_reg    = 2'd0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'd0;
        bus.alu_op        = 3'b000;
        bus.pc_source     = 2'd0;
        bus.epc_write     = 1'b0;

        case (state)
            S_RESET: state_nx = S_FETCH;
            S_FETCH: begin
                bus.pc_write  = 1'b1;
                bus.alu_src_b = 2'd1;
                bus.alu_op    = ALU_ADD;
                cnt_nx        = WAIT_INIT;
                state_nx      = S_FWAIT;
            end
            S_FWAIT: begin
                if (cnt == 3'd0) begin
                    bus.ir_write = 1'b1;
                    state_nx     = S_DECODE;
                end else begin
                    cnt_nx = cnt - 3'd1;
                end
            end
            S_DECODE: begin
                // Speculative branch target PC + (imm << 2) lands in ALUOut.
                bus.ab_write  = 1'b1;
                bus.alu_src_b = 2'd3;
                bus.alu_op    = ALU_ADD;
                case (bus.opcode)
                    OP_RTYPE:     state_nx = S_R_EXEC;
                    OP_ADDI:      state_nx = S_ADDI_EXEC;
                    OP_LW, OP_SW: state_nx = S_MEM_ADDR;
                    OP_BEQ:       state_nx = S_BEQ;
                    OP_BNE:       state_nx = S_BNE;
                    OP_J:         state_nx = S_JUMP;
                    default:      state_nx = ILLEGAL_NEXT;
                endcase
            end
            S_R_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = r_op;
                state_nx      = r_legal ? S_R_WB : ILLEGAL_NEXT;
            end
            S_R_WB: begin
                bus.reg_dst   = 2'd1;
                bus.reg_write = 1'b1;
                bus.alu_op    = r_op;
                state_nx      = S_FETCH;
            end
            S_ADDI_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                bus.alu_op    = ALU_ADD;
                state_nx      = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                bus.reg_write = 1'b1;
                state_nx      = S_FETCH;
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                bus.alu_op    = ALU_ADD;
                cnt_nx        = WAIT_INIT;
                state_nx      = (bus.opcode == OP_LW) ? S_LW_READ : S_SW_WRITE;
            end
            S_LW_READ: begin
                bus.i_or_d = 1'b1;
                if (cnt == 3'd0) state_nx = S_LW_WB;
                else             cnt_nx   = cnt - 3'd1;
            end
            S_LW_WB: begin
                bus.mem_to_reg = 2'd1;
                bus.reg_write  = 1'b1;
                state_nx       = S_FETCH;
            end
            S_SW_WRITE: begin
                bus.i_or_d    = 1'b1;
                bus.mem_write = 1'b1;
                state_nx      = S_FETCH;
            end
            S_BEQ, S_BNE: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALU_SUB;
                bus.pc_source     = 2'd1;
                bus.pc_write_cond = (state == S_BEQ) ? bus.zero : ~bus.zero;
                state_nx          = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_source = 2'd2;
                bus.pc_write  = 1'b1;
                state_nx      = S_FETCH;
            end
`ifdef MC_CTRL_EXCEPTION_EN
            S_EXC: begin
                // ALU forms PC - 4 (the faulting instruction) for EPC.
                bus.alu_src_b = 2'd1;
                bus.alu_op    = ALU_SUB;
                bus.epc_write = 1'b1;
                bus.pc_source = 2'(EXC_VECTOR_SEL);
                bus.pc_write  = 1'b1;
                state_nx      = S_FETCH;
            end
`endif
            default: state_nx = S_RESET;
        endcase
    end

    assign bus.state_dbg = state;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: each instruction is expanded into
// its per-cycle control-word sequence and compared against the DUT every cycle.
module tb_mc_control_unit;

    localparam int MEM_WAIT = 2;
    localparam int EXC_SEL  = 3;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_write;
        logic       ir_write;
        logic       ab_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       epc_write;
    } ctl_t;

    // cond: 0 = pc_write_cond as given, 1 = equals zero, 2 = equals ~zero
    typedef struct {
        ctl_t v;
        int   cond;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    ctl_t obs [0:31];
    logic [4:0] reset_code;
    int   len;

    mc_control_unit_if bus ();

    mc_control_unit #(.MEM_WAIT(MEM_WAIT), .EXC_VECTOR_SEL(EXC_SEL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL timeout: bench did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic ctl_t sample();
        ctl_t c;
        c.pc_write      = bus.pc_write;
        c.pc_write_cond = bus.pc_write_cond;
        c.i_or_d        = bus.i_or_d;
        c.mem_write     = bus.mem_write;
        c.ir_write      = bus.ir_write;
        c.ab_write      = bus.ab_write;
        c.reg_dst       = bus.reg_dst;
        c.mem_to_reg    = bus.mem_to_reg;
        c.reg_write     = bus.reg_write;
        c.alu_src_a     = bus.alu_src_a;
        c.alu_src_b     = bus.alu_src_b;
        c.alu_op        = bus.alu_op;
        c.pc_source     = bus.pc_source;
        c.epc_write     = bus.epc_write;
        return c;
    endfunction

    task automatic push(input ctl_t v, input int cond);
        exp_t e;
        e.v    = v;
        e.cond = cond;
        q.push_back(e);
    endtask

    // Control-word sequence of one instruction, derived from the instruction table.
    task automatic expand(input logic [5:0] op, input logic [5:0] fn);
        ctl_t c;
        logic [2:0] aop;
        logic legal;
        c = '0; c.pc_write = 1; c.alu_src_b = 2'd1; c.alu_op = 3'b001; push(c, 0);
        for (int i = 0; i < MEM_WAIT; i++) begin
            c = '0; c.ir_write = (i == MEM_WAIT - 1); push(c, 0);
        end
        c = '0; c.ab_write = 1; c.alu_src_b = 2'd3; c.alu_op = 3'b001; push(c, 0);
        legal = 1'b1;
        case (op)
            6'h00: begin
                aop = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : (fn == 6'h24) ? 3'b011 : 3'b000;
                c = '0; c.alu_src_a = 1; c.alu_op = aop; push(c, 0);
                if (aop == 3'b000) legal = 1'b0;
                else begin
                    c = '0; c.reg_dst = 2'd1; c.reg_write = 1; c.alu_op = aop; push(c, 0);
                end
            end
            6'h08: begin
                c = '0; c.alu_src_a = 1; c.alu_src_b = 2'd2; c.alu_op = 3'b001; push(c, 0);
                c = '0; c.reg_write = 1; push(c, 0);
            end
            6'h23, 6'h2B: begin
                c = '0; c.alu_src_a = 1; c.alu_src_b = 2'd2; c.alu_op = 3'b001; push(c, 0);
                if (op == 6'h23) begin
                    for (int i = 0; i < MEM_WAIT; i++) begin
                        c = '0; c.i_or_d = 1; push(c, 0);
                    end
                    c = '0; c.mem_to_reg = 2'd1; c.reg_write = 1; push(c, 0);
                end else begin
                    c = '0; c.i_or_d = 1; c.mem_write = 1; push(c, 0);
                end
            end
            6'h04, 6'h05: begin
                c = '0; c.alu_src_a = 1; c.alu_op = 3'b010; c.pc_source = 2'd1;
                push(c, (op == 6'h04) ? 1 : 2);
            end
            6'h02: begin
                c = '0; c.pc_source = 2'd2; c.pc_write = 1; push(c, 0);
            end
            default: legal = 1'b0;
        endcase
`ifdef MC_CTRL_EXCEPTION_EN
        if (!legal) begin
            c = '0; c.alu_src_b = 2'd1; c.alu_op = 3'b010; c.epc_write = 1;
            c.pc_source = 2'(EXC_SEL); c.pc_write = 1; push(c, 0);
        end
`else
        if (!legal) c = '0;
`endif
    endtask

    // Runs one instruction from its FETCH cycle; stops after 'limit' cycles.
    // zmode: 0 random zero, 1 zero forced 0, 2 zero forced 1.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input int limit, input int zmode, output int n);
        ctl_t exp, got;
        exp_t e;
        q.delete();
        expand(op, fn);
        n = q.size();
        for (int i = 0; i < n && i < limit; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.opcode = op;
                bus.funct  = fn;
            end
            bus.zero = (zmode == 0) ? 1'($urandom_range(0, 1)) : (zmode == 2);
            #1;
            e   = q[i];
            exp = e.v;
            if (e.cond == 1) exp.pc_write_cond = bus.zero;
            if (e.cond == 2) exp.pc_write_cond = ~bus.zero;
            got    = sample();
            obs[i] = got;
            check($sformatf("%s_c%0d", tag, i + 1), {12'b0, got}, {12'b0, exp});
            check("strobe_excl", 32'(int'(got.pc_write) + int'(got.mem_write) + int'(got.reg_write) <= 1), 32'd1);
        end
    endtask

    task automatic do_reset(input int cycles, input bool_first);
    endtask

    task automatic apply_reset(input int cycles, input bit first);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            check("reset_outputs", {12'b0, sample()}, 32'd0);
            if (first && i == 0) reset_code = bus.state_dbg;
            else check("reset_state", 32'(bus.state_dbg), 32'(reset_code));
        end
        reset = 1'b0;
    endtask

    initial begin
        int kind, lim;
        logic [5:0] op, fn;
        bus.opcode = 6'h00;
        bus.funct  = 6'h00;
        bus.zero   = 1'b0;

        apply_reset(3, 1'b1);

        run_instr("add", 6'h00, 6'h20, 99, 0, len);
        check("fetch_pc_write", 32'(obs[0].pc_write), 32'd1);
        check("fetch_alu_op", 32'(obs[0].alu_op), 32'h1);
        check("add_ir_write_c3", 32'(obs[2].ir_write), 32'd1);
        check("add_reg_write_c6", 32'(obs[5].reg_write), 32'd1);
        check("add_reg_dst_c6", 32'(obs[5].reg_dst), 32'd1);
        check("add_len", 32'(len), 32'd6);

        run_instr("lw", 6'h23, 6'h11, 99, 0, len);
        check("lw_read1_i_or_d", 32'(obs[5].i_or_d), 32'd1);
        check("lw_read2_i_or_d", 32'(obs[6].i_or_d), 32'd1);
        check("lw_wb_mem_to_reg", 32'(obs[7].mem_to_reg), 32'd1);
        check("lw_wb_reg_dst", 32'(obs[7].reg_dst), 32'd0);
        check("lw_len", 32'(len), 32'd8);

        run_instr("sw", 6'h2B, 6'h00, 99, 0, len);
        check("sw_mem_write", 32'(obs[5].mem_write), 32'd1);
        check("sw_len", 32'(len), 32'd6);

        run_instr("beq", 6'h04, 6'h00, 99, 2, len);
        check("beq_pwc", 32'(obs[4].pc_write_cond), 32'd1);
        check("beq_pc_source", 32'(obs[4].pc_source), 32'd1);
        check("beq_len", 32'(len), 32'd5);

        run_instr("bne", 6'h05, 6'h00, 99, 2, len);
        check("bne_pwc", 32'(obs[4].pc_write_cond), 32'd0);

        run_instr("j", 6'h02, 6'h00, 99, 0, len);
        check("j_pc_write", 32'(obs[4].pc_write), 32'd1);
        check("j_pc_source", 32'(obs[4].pc_source), 32'd2);
        check("j_len", 32'(len), 32'd5);

        run_instr("illegal", 6'h3F, 6'h00, 99, 0, len);
`ifdef MC_CTRL_EXCEPTION_EN
        check("exc_epc_write", 32'(obs[4].epc_write), 32'd1);
        check("exc_pc_source", 32'(obs[4].pc_source), 32'd3);
        check("exc_len", 32'(len), 32'd5);
`else
        check("illegal_len", 32'(len), 32'd4);
        check("illegal_no_strobe", 32'({obs[3].pc_write, obs[3].mem_write, obs[3].reg_write}), 32'd0);
`endif

        run_instr("illegal_funct", 6'h00, 6'h3A, 99, 0, len);

        // Abort a load in its first memory-wait cycle.
        run_instr("lw_abort", 6'h23, 6'h00, 6, 0, len);
        check("abort_in_lw_read", 32'(obs[5].i_or_d), 32'd1);
        apply_reset(1, 1'b0);

        run_instr("after_abort", 6'h08, 6'h00, 99, 0, len);
        check("fetch_state_differs", 32'(obs[0].pc_write && (reset_code != 5'h1f)), 32'd1);

        for (int k = 0; k < 200; k++) begin
            kind = $urandom_range(0, 8);
            fn   = 6'($urandom);
            case (kind)
                0: begin op = 6'h00; fn = (fn[0]) ? 6'h20 : (fn[1] ? 6'h22 : 6'h24); end
                1: op = 6'h08;
                2: op = 6'h23;
                3: op = 6'h2B;
                4: op = 6'h04;
                5: op = 6'h05;
                6: op = 6'h02;
                7: op = 6'($urandom);
                default: op = 6'h00;
            endcase
            if ($urandom_range(0, 19) == 0) begin
                lim = $urandom_range(1, 7);
                run_instr("rand_abort", op, fn, lim, 0, len);
                apply_reset($urandom_range(1, 3), 1'b0);
            end else begin
                run_instr("rand", op, fn, 99, 0, len);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle MIPS main control FSM. Sits directly downstream of the instruction-field splitter.
- Consumes opcode and funct from the instruction register fields, plus the ALU zero flag.
- Drives every datapath mux select, write enable and ALU operation for fetch, decode, execute, memory and writeback.
- Moore machine: all outputs are decoded from the registered state, except the branch PC-write qualification noted below.

Parameters:
- MEM_WAIT, 2, memory read latency in cycles (1..7); sets the length of the fetch-wait and load-wait states.
- EXC_VECTOR_SEL, 3, pc_source code that selects the exception vector (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0] from the field splitter.
- zero  in  1  ALU zero flag.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load when the branch condition is true.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- ab_write  out  1  load the A/B register-file output latches.
- reg_dst  out  2  write register select: 0 = rt, 1 = rd, 2 = $31.
- mem_to_reg  out  2  writeback select: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B input: 0 = B, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm << 2.
- alu_op  out  3  ALU operation: 001 add, 010 sub, 011 and.
- pc_source  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = exception vector.
- epc_write  out  1  EPC load (optional feature only).
- state_dbg  out  5  current state encoding.

Behaviour:
- State register and wait counter (3 bit) update on the rising clk edge.
- reset=1 at an edge: state <= RESET, counter <= 0, regardless of the current state. This aborts any instruction in progress, including mid memory-wait.
- RESET: all outputs 0. Next state is FETCH.
- Unlisted outputs are 0 in every state.
- FETCH (1 cycle): i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=add, pc_source=0, pc_write=1. Sets counter=MEM_WAIT-1. Next state is FWAIT.
- FWAIT: i_or_d=0. Counter decrements each cycle; total stay is MEM_WAIT cycles. ir_write=1 only when counter==0. Next state is DECODE when counter==0.
- DECODE (1 cycle): ab_write=1, alu_src_a=0, alu_src_b=3, alu_op=add (branch target to ALUOut). Dispatch on opcode:
  - 0x00 R_EXEC
  - 0x08 ADDI_EXEC
  - 0x23 or 0x2B MEM_ADDR
  - 0x04 BEQ
  - 0x05 BNE
  - 0x02 JUMP
  - any other opcode: FETCH (with the optional feature: EXC)
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_op from funct: 0x20 add, 0x22 sub, 0x24 and. Any other funct is treated as an illegal opcode (FETCH, or EXC with the feature). Next state is R_WB.
- R_WB: reg_dst=1, mem_to_reg=0, reg_write=1. alu_op held at the R_EXEC value. Next state is FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=2, alu_op=add. Next state is ADDI_WB.
- ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1. Next state is FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=add. Next state is LW_READ for opcode 0x23, SW_WRITE for 0x2B. Sets counter=MEM_WAIT-1.
- LW_READ: i_or_d=1. Waits MEM_WAIT cycles, same counter rule as FWAIT. Next state is LW_WB.
- LW_WB: reg_dst=0, mem_to_reg=1, reg_write=1. Next state is FETCH.
- SW_WRITE (1 cycle): i_or_d=1, mem_write=1. Next state is FETCH.
- BEQ: alu_src_a=1, alu_src_b=0, alu_op=sub, pc_source=1, pc_write_cond=zero. Next state is FETCH.
- BNE: same as BEQ but pc_write_cond=~zero.
- JUMP: pc_source=2, pc_write=1. Next state is FETCH.
- Instruction lengths with MEM_WAIT=2:
  - R-type and addi: 6 cycles
  - lw: 8 cycles
  - sw: 6 cycles
  - beq, bne, j: 5 cycles
- Opcode and funct are sampled combinationally in DECODE and R_EXEC; the IR is stable after FWAIT.
- Never asserted together: pc_write, mem_write and reg_write are never high in the same cycle.

Optional Feature:
- Macro: MC_CTRL_EXCEPTION_EN.
- Defined: an illegal opcode or funct goes to EXC (1 cycle).
  - EXC outputs: alu_src_a=0, alu_src_b=1, alu_op=sub (PC-4 to EPC), epc_write=1, pc_source=EXC_VECTOR_SEL, pc_write=1.
  - Next state is FETCH.
- Undefined: there is no EXC state, epc_write is tied to 0, and illegal instructions execute as a no-op (return to FETCH).

Test Plan:
- Reset: hold reset 3 cycles, then release → state_dbg=RESET, all outputs 0; FETCH on the next cycle with pc_write=1, alu_op=001.
- add: opcode=0x00, funct=0x20, MEM_WAIT=2 → ir_write pulses in the 3rd cycle; R_WB in cycle 6 with reg_write=1, reg_dst=1; FETCH in cycle 7.
- lw: opcode=0x23 → LW_READ lasts 2 cycles with i_or_d=1; LW_WB has mem_to_reg=1, reg_dst=0; total 8 cycles.
- Branches: beq with zero=1 → pc_write_cond=1, pc_source=1. bne with zero=1 → pc_write_cond=0. j → pc_write=1, pc_source=2. Each takes 5 cycles.
- Illegal opcode 0x3F: with MC_CTRL_EXCEPTION_EN → EXC with epc_write=1, pc_source=3. Without it → back to FETCH with no write strobes.
- Reset during LW_READ: assert reset in the 1st wait cycle → next state RESET, reg_write never asserted.
